mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter_lat_counter.sv | 36 +++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared memory-arbiter definitions: FSM states, line width, owner encoding.
// Also used by fetch, i_cache and imem.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LINE_W     = 512;
  localparam int unsigned LINE_OFS_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [LINE_W-1:0] wdata;
  } mem_req_t;

  // Clears the byte offset so every access targets a whole line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'((1 << LINE_OFS_W) - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the I/D memory arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              i_req;
  logic              i_cancel;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_ready;
  logic [LINE_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  i_req, i_cancel, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ready, d_ready, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_cancel, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ready, d_ready, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arbiter_lat_counter.sv
// Wait-state counter for the arbiter; terminal count marks the last WAIT cycle.
module lat_counter #(
  parameter int unsigned LATENCY = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc_c
);

  localparam int unsigned CNT_W = $clog2(LATENCY);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(LATENCY - 3);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_c = (count_q == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-latency arbiter sharing one line-wide memory port between I and D caches.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LATENCY = 20
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  owner_e            grant_c;
  mem_req_t          req_q, req_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              busy_q, busy_d;
  logic              cnt_clr_c, cnt_en_c, cnt_tc_c;

  lat_counter #(.LATENCY(LATENCY)) u_lat_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clr_c),
    .enable (cnt_en_c),
    .tc_c   (cnt_tc_c)
  );

  // On a tie the side that was not served last wins.
  always_comb begin
    if (bus.i_req && bus.d_req) begin
      grant_c = (last_q == OWN_I) ? OWN_D : OWN_I;
    end else if (bus.d_req) begin
      grant_c = OWN_D;
    end else begin
      grant_c = OWN_I;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    mem_en_d  = 1'b0;
    mem_we_d  = 1'b0;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    cnt_clr_c = 1'b0;
    cnt_en_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          owner_d   = grant_c;
          cnt_clr_c = 1'b1;
          state_d   = ST_WAIT;
          if (grant_c == OWN_D) begin
            req_d.addr  = line_align(bus.d_addr);
            req_d.we    = bus.d_we;
            req_d.wdata = bus.d_wdata;
          end else begin
            req_d.addr  = line_align(bus.i_addr);
            req_d.we    = 1'b0;
            req_d.wdata = '0;
          end
        end
      end
      ST_WAIT: begin
        cnt_en_c = 1'b1;
        if (owner_q == OWN_I && bus.i_cancel) begin
          state_d = ST_IDLE;
        end else if (cnt_tc_c) begin
          state_d  = ST_ACCESS;
          mem_en_d = 1'b1;
          mem_we_d = req_q.we;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (!req_q.we) begin
          rdata_d = bus.mem_rdata;
        end
        if (owner_q == OWN_I) begin
          i_ready_d = 1'b1;
        end else begin
          d_ready_d = 1'b1;
        end
      end
      ST_RESP: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_I;
      req_q     <= '0;
      rdata_q   <= '0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      req_q     <= req_d;
      rdata_q   <= rdata_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.i_ready   = i_ready_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_wdata = req_q.wdata;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LAT = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int                mem_cyc;
    int                rdy_cyc;
    owner_e            own;
    logic [31:0]       addr;
    logic              we;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
  } exp_t;

  exp_t sbq[$];

  function automatic logic [LINE_W-1:0] line_of(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = (a * 32'(k + 1)) ^ (32'hA5C3_0000 + 32'(k));
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // Memory: line content is a fixed function of the address, garbage when not enabled.
  assign bus.mem_rdata = bus.mem_en ? line_of(bus.mem_addr) : {16{32'hDEAD_BEEF}};

  // Transaction-level reference: one access at a time, fixed LAT-cycle service.
  int                cyc = 0;
  int                avail = 0;
  int                g = 0;
  bit                outst = 1'b0;
  owner_e            m_own = OWN_I;
  owner_e            m_last = OWN_I;
  logic              m_we = 1'b0;
  logic [31:0]       m_addr = '0;
  logic [LINE_W-1:0] rd_last = '0;

  always @(posedge clk) begin
    int          t;
    exp_t        e;
    logic [31:0] raw;
    t   = cyc;
    cyc = cyc + 1;
    if (reset) begin
      sbq.delete();
      outst   = 1'b0;
      avail   = t + 1;
      m_last  = OWN_I;
      rd_last = '0;
    end else begin
      if (outst && m_own == OWN_I && bus.i_cancel && t >= g + 1 && t <= g + LAT - 2) begin
        sbq.delete();
        outst = 1'b0;
        avail = t + 1;
      end else if (outst && t == g + LAT) begin
        outst  = 1'b0;
        m_last = m_own;
        if (!m_we) rd_last = line_of(m_addr);
      end
      if (!outst && t >= avail && (bus.i_req || bus.d_req)) begin
        if (bus.i_req && bus.d_req) m_own = (m_last == OWN_D) ? OWN_I : OWN_D;
        else m_own = bus.d_req ? OWN_D : OWN_I;
        raw     = (m_own == OWN_D) ? bus.d_addr : bus.i_addr;
        m_addr  = {raw[31:6], 6'b0};
        m_we    = (m_own == OWN_D) ? bus.d_we : 1'b0;
        e.wdata = bus.d_wdata;
        e.own   = m_own;
        e.addr  = m_addr;
        e.we    = m_we;
        e.rdata = m_we ? rd_last : line_of(m_addr);
        e.mem_cyc = t + LAT - 1;
        e.rdy_cyc = t + LAT;
        g       = t;
        outst   = 1'b1;
        avail   = t + LAT + 1;
        sbq.push_back(e);
      end
    end
  end

  // Monitor / checker.
  int checks = 0;
  int failures = 0;
  int last_mem_cyc = -100;
  bit done = 1'b0;

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      chk("final_queue_empty", LINE_W'(sbq.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end else if (reset) begin
      chk("rst_busy",      LINE_W'(bus.busy),    '0);
      chk("rst_mem_en",    LINE_W'(bus.mem_en),  '0);
      chk("rst_mem_we",    LINE_W'(bus.mem_we),  '0);
      chk("rst_i_ready",   LINE_W'(bus.i_ready), '0);
      chk("rst_d_ready",   LINE_W'(bus.d_ready), '0);
      chk("rst_rdata",     bus.rdata,            '0);
      chk("rst_mem_addr",  LINE_W'(bus.mem_addr), '0);
      chk("rst_mem_wdata", bus.mem_wdata,        '0);
    end else begin
      chk("busy", LINE_W'(bus.busy), LINE_W'(outst));
      if (!bus.mem_en) chk("mem_we_without_en", LINE_W'(bus.mem_we), '0);
      if (bus.mem_en) begin
        chk("mem_en_expected", LINE_W'(sbq.size() != 0), LINE_W'(1));
        if (sbq.size() != 0) begin
          last_mem_cyc = cyc;
          chk("mem_en_cycle", LINE_W'(cyc), LINE_W'(sbq[0].mem_cyc));
          chk("mem_addr", LINE_W'(bus.mem_addr), LINE_W'(sbq[0].addr));
          chk("mem_we", LINE_W'(bus.mem_we), LINE_W'(sbq[0].we));
          if (sbq[0].we) chk("mem_wdata", bus.mem_wdata, sbq[0].wdata);
        end
      end
      if (bus.i_ready || bus.d_ready) begin
        chk("ready_expected", LINE_W'(sbq.size() != 0), LINE_W'(1));
        if (sbq.size() != 0) begin
          chk("ready_cycle", LINE_W'(cyc), LINE_W'(sbq[0].rdy_cyc));
          chk("mem_en_before_ready", LINE_W'(last_mem_cyc), LINE_W'(sbq[0].rdy_cyc - 1));
          chk("i_ready", LINE_W'(bus.i_ready), LINE_W'(sbq[0].own == OWN_I));
          chk("d_ready", LINE_W'(bus.d_ready), LINE_W'(sbq[0].own == OWN_D));
          chk("rdata", bus.rdata, sbq[0].rdata);
          void'(sbq.pop_front());
        end
      end else if (sbq.size() != 0 && cyc > sbq[0].rdy_cyc) begin
        chk("ready_timeout", LINE_W'(cyc), LINE_W'(sbq[0].rdy_cyc));
        void'(sbq.pop_front());
      end
    end
  end

  // Stimulus: one process plays the I client, the D client and the reset source.
  bit i_pend = 1'b0;
  bit d_pend = 1'b0;
  bit i_seen = 1'b0;
  bit d_seen = 1'b0;

  task automatic step();
    @(negedge clk);
    i_seen = bus.i_ready;
    d_seen = bus.d_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit new_ok);
    bus.i_cancel = 1'b0;
    if (i_pend) begin
      if (i_seen) begin
        i_pend = 1'b0;
        bus.i_req = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        bus.i_cancel = 1'b1;
        bus.i_req = 1'b0;
        i_pend = 1'b0;
      end else begin
        bus.i_addr = $urandom;
      end
    end else if (new_ok && $urandom_range(0, 3) == 0) begin
      i_pend = 1'b1;
      bus.i_req = 1'b1;
      bus.i_addr = $urandom;
    end
    if (d_pend) begin
      if (d_seen) begin
        d_pend = 1'b0;
        bus.d_req = 1'b0;
      end else begin
        bus.d_addr  = $urandom;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_wdata = rand_line();
      end
    end else if (new_ok && $urandom_range(0, 3) == 0) begin
      d_pend = 1'b1;
      bus.d_req   = 1'b1;
      bus.d_addr  = $urandom;
      bus.d_we    = 1'($urandom_range(0, 1));
      bus.d_wdata = rand_line();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.i_req = 1'b0; bus.i_cancel = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    // Tie straight out of reset: D must win first.
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0044; i_pend = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_1080; d_pend = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      step();
      drive(1'b1);
    end
    for (int n = 0; n < 400 && (i_pend || d_pend); n++) begin
      step();
      drive(1'b0);
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.i_cancel = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0;
    repeat (LAT + 3) step();
    // Reset ten cycles into a D refill, request kept asserted across it.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_2345;
    repeat (11) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 3 * LAT; n++) begin
      step();
      if (d_seen) break;
    end
    bus.d_req = 1'b0;
    repeat (LAT + 3) step();
    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("FAIL tb_no_finish");
    $fatal(1);
  end

endmodule
